// File: rtl/hmc_link_pwr_seq.sv
// hmc_link_pwr_seq
// Drives the HMC sideband pins P_RST_N and LXRXPS. It runs the cold-reset release
// and the LXRXPS/LXTXPS sleep-entry and wake handshakes, and watches FERR_N for
// fatal errors.
//
// Ports
//   clk, res_n      single rising-edge clock, asynchronous active-low reset
//   cfg_hmc_reset   1-cycle pulse, restarts the cold-reset sequence from any state
//   cfg_sleep_req   level, 1 = request sleep, 0 = request active
//   P_RST_N         HMC reset output, active-low (registered)
//   LXRXPS          host->HMC power state, 1 = active (registered)
//   LXTXPS          HMC->host power state, asynchronous input
//   FERR_N          HMC fatal error, active-low, asynchronous input
//   link_up         1 only in ST_ACTIVE (registered)
//   sleep_ack       1 only in ST_SLEEP (registered)
//   fatal_err       sticky, FERR_N seen low
//   timeout_err     sticky, LXTXPS response timeout
//   state           current FSM state code
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_RST    0| P_RST_N held low for RST_CYCLES clocks
// ST_WAIT   1| reset released, waiting for LXTXPS to go high
// ST_ACTIVE 2| link active
// ST_SLP_EN 3| LXRXPS low, waiting for LXTXPS to go low
// ST_SLEEP  4| link asleep
// ST_WAKE   5| LXRXPS high, waiting for LXTXPS to go high
// ST_ERR    6| fatal error or handshake timeout, pins frozen
module hmc_link_pwr_seq #(
    parameter int RST_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       res_n,
    input  logic       cfg_hmc_reset,
    input  logic       cfg_sleep_req,
    output logic       P_RST_N,
    output logic       LXRXPS,
    input  logic       LXTXPS,
    input  logic       FERR_N,
    output logic       link_up,
    output logic       sleep_ack,
    output logic       fatal_err,
    output logic       timeout_err,
    output logic [2:0] state
);

    localparam int CNT_SPAN = (RST_CYCLES > TIMEOUT_CYCLES) ? RST_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W    = $clog2(CNT_SPAN) + 1;

    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = '1;

    typedef enum logic [2:0] {
        ST_RST    = 3'd0,
        ST_WAIT   = 3'd1,
        ST_ACTIVE = 3'd2,
        ST_SLP_EN = 3'd3,
        ST_SLEEP  = 3'd4,
        ST_WAKE   = 3'd5,
        ST_ERR    = 3'd6
    } state_t;

    state_t           st_q, st_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             prst_d, lxrxps_d, fatal_d, tout_d;
    logic             timeout_hit;

    logic [SYNC_STAGES-1:0] lxtxps_sync;
    logic [SYNC_STAGES-1:0] ferr_sync;
    logic                   lxtxps_s;
    logic                   ferr_n_s;

    // LXTXPS carries no meaning while the HMC is held in reset, so its
    // synchroniser is flushed to 0 while P_RST_N is low. After release the FSM
    // therefore only sees LXTXPS high once it has crossed the full sync chain.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            lxtxps_sync <= '1;
            ferr_sync   <= '1;
        end else begin
            ferr_sync <= {ferr_sync[SYNC_STAGES-2:0], FERR_N};
            if (!P_RST_N)
                lxtxps_sync <= '0;
            else
                lxtxps_sync <= {lxtxps_sync[SYNC_STAGES-2:0], LXTXPS};
        end
    end

    assign lxtxps_s = lxtxps_sync[SYNC_STAGES-1];
    assign ferr_n_s = ferr_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            st_q        <= ST_RST;
            cnt_q       <= '0;
            P_RST_N     <= 1'b0;
            LXRXPS      <= 1'b1;
            link_up     <= 1'b0;
            sleep_ack   <= 1'b0;
            fatal_err   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            st_q        <= st_d;
            cnt_q       <= cnt_d;
            P_RST_N     <= prst_d;
            LXRXPS      <= lxrxps_d;
            link_up     <= (st_d == ST_ACTIVE);
            sleep_ack   <= (st_d == ST_SLEEP);
            fatal_err   <= fatal_d;
            timeout_err <= tout_d;
        end
    end

    always_comb begin
        st_d        = st_q;
        cnt_d       = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
        prst_d      = P_RST_N;
        lxrxps_d    = LXRXPS;
        fatal_d     = fatal_err;
        tout_d      = timeout_err;
        timeout_hit = (st_q inside {ST_WAIT, ST_SLP_EN, ST_WAKE}) && (cnt_q == TO_LAST);

        if (cfg_hmc_reset) begin
            st_d     = ST_RST;
            prst_d   = 1'b0;
            lxrxps_d = 1'b1;
            fatal_d  = 1'b0;
            tout_d   = 1'b0;
        // Already in ST_ERR, a later FERR_N is not recorded, so the two sticky
        // flags only coexist when the timeout and FERR_N land on the same cycle.
        end else if (!ferr_n_s && st_q != ST_RST && st_q != ST_ERR) begin
            st_d    = ST_ERR;
            fatal_d = 1'b1;
            if (timeout_hit)
                tout_d = 1'b1;
        end else if (timeout_hit) begin
            st_d   = ST_ERR;
            tout_d = 1'b1;
        end else begin
            case (st_q)
                ST_RST: begin
                    prst_d   = 1'b0;
                    lxrxps_d = 1'b1;
                    if (cnt_q == RST_LAST) begin
                        prst_d = 1'b1;
                        st_d   = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (lxtxps_s)
                        st_d = ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    if (cfg_sleep_req) begin
                        lxrxps_d = 1'b0;
                        st_d     = ST_SLP_EN;
                    end
                end
                ST_SLP_EN: begin
                    if (!lxtxps_s)
                        st_d = ST_SLEEP;
                end
                ST_SLEEP: begin
                    if (!cfg_sleep_req) begin
                        lxrxps_d = 1'b1;
                        st_d     = ST_WAKE;
                    end
                end
                ST_WAKE: begin
                    if (lxtxps_s)
                        st_d = ST_ACTIVE;
                end
                default: st_d = ST_ERR;
            endcase
        end

        // A reset pulse while already in ST_RST must also restart the count.
        if (st_d != st_q || cfg_hmc_reset)
            cnt_d = '0;
    end

    assign state = st_q;

endmodule

// File: tb/tb_hmc_link_pwr_seq.sv
// tb_hmc_link_pwr_seq
// Directed stimulus for hmc_link_pwr_seq. The stimulus process pushes the
// expected output vector for a given clock index into a queue; the monitor
// samples the DUT on every falling edge and compares against queue entries
// whose clock index has been reached.
module tb_hmc_link_pwr_seq;

    localparam int RST_CYCLES     = 16;
    localparam int TIMEOUT_CYCLES = 1024;
    localparam int SYNC_STAGES    = 2;

    logic       clk = 1'b0;
    logic       res_n;
    logic       cfg_hmc_reset;
    logic       cfg_sleep_req;
    logic       P_RST_N;
    logic       LXRXPS;
    logic       LXTXPS;
    logic       FERR_N;
    logic       link_up;
    logic       sleep_ack;
    logic       fatal_err;
    logic       timeout_err;
    logic [2:0] state;

    hmc_link_pwr_seq #(
        .RST_CYCLES     (RST_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .SYNC_STAGES    (SYNC_STAGES)
    ) dut (
        .clk           (clk),
        .res_n         (res_n),
        .cfg_hmc_reset (cfg_hmc_reset),
        .cfg_sleep_req (cfg_sleep_req),
        .P_RST_N       (P_RST_N),
        .LXRXPS        (LXRXPS),
        .LXTXPS        (LXTXPS),
        .FERR_N        (FERR_N),
        .link_up       (link_up),
        .sleep_ack     (sleep_ack),
        .fatal_err     (fatal_err),
        .timeout_err   (timeout_err),
        .state         (state)
    );

    always #5 clk = ~clk;

    // Number of rising edges seen so far.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Vector order: state[2:0], P_RST_N, LXRXPS, link_up, sleep_ack, fatal_err, timeout_err
    typedef struct {
        int         cyc;
        string      name;
        logic [8:0] exp;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic push(input int c, input string nm, input logic [2:0] st,
                        input logic p, input logic lx, input logic lu,
                        input logic sa, input logic fe, input logic te);
        exp_t e;
        e.cyc  = c;
        e.name = nm;
        e.exp  = {st, p, lx, lu, sa, fe, te};
        sb.push_back(e);
    endtask

    // Returns 1 time unit after the rising edge that makes cyc reach c.
    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    exp_t       mon_e;
    logic [8:0] mon_act;
    always @(negedge clk) begin
        mon_act = {state, P_RST_N, LXRXPS, link_up, sleep_ack, fatal_err, timeout_err};
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            mon_e  = sb.pop_front();
            checks = checks + 1;
            if (mon_e.cyc < cyc) begin
                errors = errors + 1;
                $display("FAIL %s: sample for cycle %0d missed (now %0d)", mon_e.name, mon_e.cyc, cyc);
            end else if (mon_act !== mon_e.exp) begin
                errors = errors + 1;
                $display("FAIL %s: cycle %0d got st=%0d prst=%b lxrxps=%b lu=%b sa=%b fe=%b te=%b, expected st=%0d prst=%b lxrxps=%b lu=%b sa=%b fe=%b te=%b",
                         mon_e.name, cyc,
                         mon_act[8:6], mon_act[5], mon_act[4], mon_act[3], mon_act[2], mon_act[1], mon_act[0],
                         mon_e.exp[8:6], mon_e.exp[5], mon_e.exp[4], mon_e.exp[3], mon_e.exp[2], mon_e.exp[1], mon_e.exp[0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, f, r, a, n1, p;
        res_n         = 1'b0;
        cfg_hmc_reset = 1'b0;
        cfg_sleep_req = 1'b0;
        LXTXPS        = 1'b1;
        FERR_N        = 1'b1;

        // Cold reset with LXTXPS held high.
        goto(3);
        n0 = cyc;
        push(n0,      "reset_values",    3'd0, 0, 1, 0, 0, 0, 0);
        res_n = 1'b1;
        push(n0 + 15, "rst_hold",        3'd0, 0, 1, 0, 0, 0, 0);
        push(n0 + 16, "prst_release",    3'd1, 1, 1, 0, 0, 0, 0);
        push(n0 + 18, "wait_sync",       3'd1, 1, 1, 0, 0, 0, 0);
        push(n0 + 19, "link_up",         3'd2, 1, 1, 1, 0, 0, 0);
        goto(n0 + 22);

        // One-clock FERR_N pulse in ST_ACTIVE, then recovery by cfg_hmc_reset.
        f = cyc;
        FERR_N = 1'b0;
        goto(f + 1);
        FERR_N = 1'b1;
        push(f + 2,  "ferr_sync_lat",    3'd2, 1, 1, 1, 0, 0, 0);
        push(f + 3,  "fatal_entry",      3'd6, 1, 1, 0, 0, 1, 0);
        push(f + 13, "err_hold",         3'd6, 1, 1, 0, 0, 1, 0);
        goto(f + 15);
        r = cyc;
        cfg_hmc_reset = 1'b1;
        goto(r + 1);
        cfg_hmc_reset = 1'b0;
        push(r + 1,  "cfg_reset",        3'd0, 0, 1, 0, 0, 0, 0);
        push(r + 17, "rerelease",        3'd1, 1, 1, 0, 0, 0, 0);
        push(r + 20, "relink",           3'd2, 1, 1, 1, 0, 0, 0);
        goto(r + 22);

        // cfg_hmc_reset in the same cycle the synced FERR_N is low.
        f = cyc;
        FERR_N = 1'b0;
        goto(f + 1);
        FERR_N = 1'b1;
        goto(f + 2);
        cfg_hmc_reset = 1'b1;
        goto(f + 3);
        cfg_hmc_reset = 1'b0;
        push(f + 3,  "reset_beats_ferr", 3'd0, 0, 1, 0, 0, 0, 0);
        push(f + 4,  "no_fatal_after",   3'd0, 0, 1, 0, 0, 0, 0);
        r = f + 3;
        // FERR_N low while the HMC is held in reset is ignored.
        goto(r + 3);
        FERR_N = 1'b0;
        goto(r + 4);
        FERR_N = 1'b1;
        push(r + 7,  "ferr_in_rst_ign",  3'd0, 0, 1, 0, 0, 0, 0);
        push(r + 16, "rerelease_2",      3'd1, 1, 1, 0, 0, 0, 0);
        push(r + 19, "relink_2",         3'd2, 1, 1, 1, 0, 0, 0);
        goto(r + 21);

        // Sleep entry and wake, with request changes mid-handshake.
        a = cyc;
        cfg_sleep_req = 1'b1;
        push(a + 1,  "slp_en",           3'd3, 1, 0, 0, 0, 0, 0);
        goto(a + 3);
        cfg_sleep_req = 1'b0;
        goto(a + 6);
        LXTXPS = 1'b0;
        push(a + 8,  "slp_en_wait",      3'd3, 1, 0, 0, 0, 0, 0);
        push(a + 9,  "sleep_ack",        3'd4, 1, 0, 0, 1, 0, 0);
        push(a + 10, "wake",             3'd5, 1, 1, 0, 0, 0, 0);
        goto(a + 11);
        cfg_sleep_req = 1'b1;
        goto(a + 13);
        LXTXPS = 1'b1;
        push(a + 15, "wake_wait",        3'd5, 1, 1, 0, 0, 0, 0);
        push(a + 16, "relink_wake",      3'd2, 1, 1, 1, 0, 0, 0);
        push(a + 17, "deferred_sleep",   3'd3, 1, 0, 0, 0, 0, 0);
        push(a + 18, "slp_en_pre_rst",   3'd3, 1, 0, 0, 0, 0, 0);
        goto(a + 19);
        // Asynchronous reset between clock edges while in ST_SLP_EN.
        #3;
        res_n = 1'b0;
        push(a + 19, "async_reset",      3'd0, 0, 1, 0, 0, 0, 0);

        // No LXTXPS response after release: handshake timeout.
        cfg_sleep_req = 1'b0;
        LXTXPS        = 1'b0;
        goto(a + 22);
        n1 = cyc;
        res_n = 1'b1;
        p = n1 + RST_CYCLES;
        push(p,        "prst_release_3", 3'd1, 1, 1, 0, 0, 0, 0);
        push(p + 1023, "timeout_minus1", 3'd1, 1, 1, 0, 0, 0, 0);
        push(p + 1024, "timeout",        3'd6, 1, 1, 0, 0, 0, 1);
        push(p + 1030, "timeout_hold",   3'd6, 1, 1, 0, 0, 0, 1);
        goto(p + 1033);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
